// File: rtl/dispatch_sched_pkg.sv
// Shared types and constants for the in-order dispatch scheduler:
// RV32 major opcodes, the unit-class enum, the IQ entry layout and
// the opcode-to-unit classifier.
package dispatch_sched_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    CLS_RS      = 2'd0,
    CLS_LSB     = 2'd1,
    CLS_ILLEGAL = 2'd2
  } unit_cls_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        isjump;
    logic [31:0] wrong_pc;
  } iq_entry_t;

  // Map a major opcode to the unit that executes it; anything unknown is illegal.
  function automatic unit_cls_e classify_op(input logic [6:0] op);
    unit_cls_e cls;
    case (op)
      OP_LOAD, OP_STORE: cls = CLS_LSB;
      OP_IMM, OP_REG, OP_AUIPC, OP_LUI,
      OP_JAL, OP_JALR, OP_BRANCH: cls = CLS_RS;
      default: cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// Circular instruction queue. One push and one pop per cycle, a flush that
// empties it, and a global enable that freezes all state when low.
// Push is refused when full and pop is refused when empty.
module dispatch_fifo
  import dispatch_sched_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  iq_entry_t        wr_data_i,
  output iq_entry_t        rd_data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o
);

  iq_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic             full_s;

  // Guard push/pop against overflow/underflow and compute next pointers and count.
  always_comb begin
    full_s    = (count_q == CNT_W'(DEPTH));
    push_ok_s = push_i && !full_s && !flush_i;
    pop_ok_s  = pop_i && (count_q != {CNT_W{1'b0}}) && !flush_i;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (flush_i) begin
      head_d  = {PTR_W{1'b0}};
      tail_d  = {PTR_W{1'b0}};
      count_d = {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        tail_d = tail_q + PTR_W'(1);
      end else begin
        tail_d = tail_q;
      end
      if (pop_ok_s) begin
        head_d = head_q + PTR_W'(1);
      end else begin
        head_d = head_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else if (en_i) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset is needed.
  always_ff @(posedge clk) begin
    if (rst && en_i && push_ok_s) begin
      mem_q[tail_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[head_q];
  assign count_o   = count_q;
  assign full_o    = full_s;

endmodule

// File: rtl/dispatch_sched.sv
// In-order dispatch scheduler: buffers fetched instructions, classifies the
// head as LSB- or RS-bound, releases it when the ROB and its unit have room,
// and allocates ROB tags in order. A flush clears the queue and the tag.
module dispatch_sched
  import dispatch_sched_pkg::*;
#(
  parameter  int IQ_DEPTH = 4,
  parameter  int ROB_SIZE = 16,
  localparam int ROB_W    = $clog2(ROB_SIZE),
  localparam int CNT_W    = $clog2(IQ_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_instr,
  input  logic [31:0]      fetch_pc,
  input  logic             fetch_isjump,
  input  logic [31:0]      fetch_jump_wrong_to_pc,
  output logic             fetch_ready,
  input  logic             flush,
  input  logic             ROB_full,
  input  logic             LSB_full,
  input  logic             RS_full,
  output logic             issue_valid,
  output logic [31:0]      issue_instr,
  output logic [31:0]      issue_pc,
  output logic             issue_isjump,
  output logic [31:0]      issue_jump_wrong_to_pc,
  output logic [ROB_W-1:0] issue_rob_tag,
  output logic             issue_to_lsb,
  output logic             issue_to_rs,
  output logic [31:0]      stall_cycles
);

  iq_entry_t        wr_entry_s;
  iq_entry_t        head_s;
  logic [CNT_W-1:0] count_s;
  logic             full_s;
  unit_cls_e        head_cls_s;
  logic             not_empty_s;
  logic             unit_free_s;
  logic             push_s;
  logic             pop_s;
  logic             dispatch_s;
  logic             drop_s;
  logic             stall_s;

  logic             issue_valid_q,  issue_valid_d;
  logic [31:0]      issue_instr_q,  issue_instr_d;
  logic [31:0]      issue_pc_q,     issue_pc_d;
  logic             issue_isjump_q, issue_isjump_d;
  logic [31:0]      issue_wpc_q,    issue_wpc_d;
  logic [ROB_W-1:0] issue_tag_q,    issue_tag_d;
  logic             issue_lsb_q,    issue_lsb_d;
  logic             issue_rs_q,     issue_rs_d;
  logic [ROB_W-1:0] rob_tag_q,      rob_tag_d;
  logic [31:0]      stall_q,        stall_d;

  assign wr_entry_s = '{instr:    fetch_instr,
                        pc:       fetch_pc,
                        isjump:   fetch_isjump,
                        wrong_pc: fetch_jump_wrong_to_pc};

  dispatch_fifo #(
    .DEPTH (IQ_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .en_i      (rdy),
    .push_i    (push_s),
    .pop_i     (pop_s),
    .flush_i   (flush),
    .wr_data_i (wr_entry_s),
    .rd_data_o (head_s),
    .count_o   (count_s),
    .full_o    (full_s)
  );

  // Classify the head and decide dispatch / drop / stall for this cycle.
  always_comb begin
    not_empty_s = (count_s != {CNT_W{1'b0}});
    head_cls_s  = classify_op(head_s.instr[6:0]);
    case (head_cls_s)
      CLS_LSB: unit_free_s = !LSB_full;
      CLS_RS:  unit_free_s = !RS_full;
      default: unit_free_s = 1'b0;
    endcase
    push_s     = fetch_valid && !full_s && !flush;
    dispatch_s = not_empty_s && !flush && !ROB_full && unit_free_s;
    // Illegal heads are discarded silently so they cannot wedge the queue.
    drop_s     = not_empty_s && !flush && (head_cls_s == CLS_ILLEGAL);
    pop_s      = dispatch_s || drop_s;
    stall_s    = not_empty_s && !flush && (head_cls_s != CLS_ILLEGAL) && !dispatch_s;
  end

  // Next values for the registered issue port, ROB tag and stall counter.
  always_comb begin
    issue_valid_d  = 1'b0;
    issue_instr_d  = issue_instr_q;
    issue_pc_d     = issue_pc_q;
    issue_isjump_d = issue_isjump_q;
    issue_wpc_d    = issue_wpc_q;
    issue_tag_d    = issue_tag_q;
    issue_lsb_d    = issue_lsb_q;
    issue_rs_d     = issue_rs_q;
    rob_tag_d      = rob_tag_q;
    if (flush) begin
      rob_tag_d = {ROB_W{1'b0}};
    end else if (dispatch_s) begin
      issue_valid_d  = 1'b1;
      issue_instr_d  = head_s.instr;
      issue_pc_d     = head_s.pc;
      issue_isjump_d = head_s.isjump;
      issue_wpc_d    = head_s.wrong_pc;
      issue_tag_d    = rob_tag_q;
      issue_lsb_d    = (head_cls_s == CLS_LSB);
      issue_rs_d     = (head_cls_s == CLS_RS);
      rob_tag_d      = rob_tag_q + ROB_W'(1);
    end else begin
      issue_valid_d = 1'b0;
    end
    if (stall_s) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Output and bookkeeping registers; everything freezes while rdy is low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      issue_valid_q  <= 1'b0;
      issue_instr_q  <= 32'd0;
      issue_pc_q     <= 32'd0;
      issue_isjump_q <= 1'b0;
      issue_wpc_q    <= 32'd0;
      issue_tag_q    <= {ROB_W{1'b0}};
      issue_lsb_q    <= 1'b0;
      issue_rs_q     <= 1'b0;
      rob_tag_q      <= {ROB_W{1'b0}};
      stall_q        <= 32'd0;
    end else if (rdy) begin
      issue_valid_q  <= issue_valid_d;
      issue_instr_q  <= issue_instr_d;
      issue_pc_q     <= issue_pc_d;
      issue_isjump_q <= issue_isjump_d;
      issue_wpc_q    <= issue_wpc_d;
      issue_tag_q    <= issue_tag_d;
      issue_lsb_q    <= issue_lsb_d;
      issue_rs_q     <= issue_rs_d;
      rob_tag_q      <= rob_tag_d;
      stall_q        <= stall_d;
    end
  end

  assign fetch_ready            = !full_s;
  assign issue_valid            = issue_valid_q;
  assign issue_instr            = issue_instr_q;
  assign issue_pc               = issue_pc_q;
  assign issue_isjump           = issue_isjump_q;
  assign issue_jump_wrong_to_pc = issue_wpc_q;
  assign issue_rob_tag          = issue_tag_q;
  assign issue_to_lsb           = issue_lsb_q;
  assign issue_to_rs            = issue_rs_q;
  assign stall_cycles           = stall_q;

endmodule

// File: tb/tb_dispatch_sched.sv
// Self-checking bench for dispatch_sched: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// queue-based model of the scheduler.
module tb_dispatch_sched;

  localparam int DEPTH = 4;
  localparam int RSZ   = 16;

  logic        clk = 1'b0;
  logic        rst, rdy, fetch_valid, fetch_isjump, flush;
  logic [31:0] fetch_instr, fetch_pc, fetch_wpc;
  logic        rob_full, lsb_full, rs_full;
  logic        fetch_ready, issue_valid, issue_isjump, issue_to_lsb, issue_to_rs;
  logic [31:0] issue_instr, issue_pc, issue_wpc, stall_cycles;
  logic [3:0]  issue_rob_tag;

  dispatch_sched #(.IQ_DEPTH(DEPTH), .ROB_SIZE(RSZ)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .fetch_isjump(fetch_isjump), .fetch_jump_wrong_to_pc(fetch_wpc),
    .fetch_ready(fetch_ready), .flush(flush),
    .ROB_full(rob_full), .LSB_full(lsb_full), .RS_full(rs_full),
    .issue_valid(issue_valid), .issue_instr(issue_instr), .issue_pc(issue_pc),
    .issue_isjump(issue_isjump), .issue_jump_wrong_to_pc(issue_wpc),
    .issue_rob_tag(issue_rob_tag), .issue_to_lsb(issue_to_lsb),
    .issue_to_rs(issue_to_rs), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        isj;
    logic [31:0] wpc;
  } ent_t;

  ent_t        mq[$];
  int          m_tag;
  logic        e_valid, e_isj, e_lsb, e_rs;
  logic [31:0] e_instr, e_pc, e_wpc, e_stall;
  int          e_tag;

  // 0 = RS, 1 = LSB, 2 = illegal
  function automatic int cls_of(input logic [31:0] ins);
    case (ins[6:0])
      7'b0000011, 7'b0100011: return 1;
      7'b0010011, 7'b0110011, 7'b0010111, 7'b0110111,
      7'b1101111, 7'b1100111, 7'b1100011: return 0;
      default: return 2;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit   can_push;
    int   c;
    ent_t h;
    if (!rst) begin
      mq.delete();
      m_tag = 0; e_stall = 32'd0; e_valid = 1'b0; e_instr = 32'd0; e_pc = 32'd0;
      e_isj = 1'b0; e_wpc = 32'd0; e_tag = 0; e_lsb = 1'b0; e_rs = 1'b0;
    end else if (rdy) begin
      if (flush) begin
        mq.delete();
        m_tag = 0;
        e_valid = 1'b0;
      end else begin
        can_push = fetch_valid && (mq.size() != DEPTH);
        e_valid = 1'b0;
        if (mq.size() > 0) begin
          c = cls_of(mq[0].instr);
          if (c == 2) begin
            void'(mq.pop_front());
          end else if (!rob_full && ((c == 1) ? !lsb_full : !rs_full)) begin
            h = mq.pop_front();
            e_valid = 1'b1; e_instr = h.instr; e_pc = h.pc; e_isj = h.isj; e_wpc = h.wpc;
            e_tag = m_tag; m_tag = (m_tag + 1) % RSZ;
            e_lsb = (c == 1); e_rs = (c == 0);
          end else begin
            e_stall = e_stall + 32'd1;
          end
        end
        if (can_push) mq.push_back('{fetch_instr, fetch_pc, fetch_isjump, fetch_wpc});
      end
    end
  endtask

  // Compare every DUT output against the model shortly after each active edge.
  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      chk("fetch_ready",  {31'd0, fetch_ready},  {31'd0, (mq.size() != DEPTH)});
      chk("issue_valid",  {31'd0, issue_valid},  {31'd0, e_valid});
      chk("issue_instr",  issue_instr,           e_instr);
      chk("issue_pc",     issue_pc,              e_pc);
      chk("issue_isjump", {31'd0, issue_isjump}, {31'd0, e_isj});
      chk("issue_wpc",    issue_wpc,             e_wpc);
      chk("issue_tag",    {28'd0, issue_rob_tag}, e_tag);
      chk("issue_to_lsb", {31'd0, issue_to_lsb}, {31'd0, e_lsb});
      chk("issue_to_rs",  {31'd0, issue_to_rs},  {31'd0, e_rs});
      chk("stall_cycles", stall_cycles,          e_stall);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b1; rdy = 1'b1; fetch_valid = 1'b0; flush = 1'b0;
    fetch_instr = 32'd0; fetch_pc = 32'd0; fetch_isjump = 1'b0; fetch_wpc = 32'd0;
    rob_full = 1'b0; lsb_full = 1'b0; rs_full = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
    fetch_valid = 1'b1; fetch_instr = ins; fetch_pc = pc;
    fetch_isjump = pc[2]; fetch_wpc = pc + 32'h40;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10];
    ops = '{7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0010111,
            7'b0110111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b1111111};
    return {$urandom_range(0, 32'h1FF_FFFF), ops[$urandom_range(0, 9)]};
  endfunction

  localparam logic [31:0] ADDI = 32'h0010_0093;
  localparam logic [31:0] LW   = 32'h0000_A103;

  initial begin
    idle();
    rst = 1'b0;
    cmp_en = 1'b1;
    tick();
    chk("reset_valid", {31'd0, issue_valid}, 32'd0);
    chk("reset_stall", stall_cycles, 32'd0);
    chk("reset_ready", {31'd0, fetch_ready}, 32'd1);

    // ADDI issues to RS with tag 0 one cycle after its push
    do_reset();
    offer(ADDI, 32'h0); tick();
    fetch_valid = 1'b0; tick();
    chk("addi_valid", {31'd0, issue_valid}, 32'd1);
    chk("addi_rs", {31'd0, issue_to_rs}, 32'd1);
    chk("addi_tag", {28'd0, issue_rob_tag}, 32'd0);
    chk("addi_pc", issue_pc, 32'h0);

    // LW blocked by LSB_full for 3 cycles
    do_reset();
    lsb_full = 1'b1;
    offer(LW, 32'h8); tick();
    fetch_valid = 1'b0;
    repeat (3) tick();
    chk("lw_blocked", {31'd0, issue_valid}, 32'd0);
    chk("lw_stall3", stall_cycles, 32'd3);
    lsb_full = 1'b0; tick();
    chk("lw_lsb", {31'd0, issue_to_lsb}, 32'd1);
    chk("lw_tag", {28'd0, issue_rob_tag}, 32'd0);

    // Fill behind ROB_full, then drain in order
    do_reset();
    rob_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      offer(ADDI, 32'h100 + 32'(4 * i)); tick();
      if (i == 3) chk("full_ready_low", {31'd0, fetch_ready}, 32'd0);
    end
    fetch_valid = 1'b0; rob_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_valid", {31'd0, issue_valid}, 32'd1);
      chk("drain_tag", {28'd0, issue_rob_tag}, 32'(i));
      chk("drain_pc", issue_pc, 32'h100 + 32'(4 * i));
    end
    tick();
    chk("drain_done", {31'd0, issue_valid}, 32'd0);

    // Flush with a simultaneous fetch
    do_reset();
    rob_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(ADDI, 32'h200 + 32'(4 * i)); tick();
    end
    flush = 1'b1; offer(ADDI, 32'h300); tick();
    chk("flush_empty", {31'd0, fetch_ready}, 32'd1);
    chk("flush_valid", {31'd0, issue_valid}, 32'd0);
    flush = 1'b0; fetch_valid = 1'b0; rob_full = 1'b0; tick();
    chk("flush_noissue", {31'd0, issue_valid}, 32'd0);
    offer(ADDI, 32'h400); tick();
    fetch_valid = 1'b0; tick();
    chk("post_flush_valid", {31'd0, issue_valid}, 32'd1);
    chk("post_flush_tag", {28'd0, issue_rob_tag}, 32'd0);

    // 17 back-to-back ADDIs: tag wraps 15 -> 0
    do_reset();
    for (int t = 0; t < 18; t++) begin
      if (t < 17) offer(ADDI, 32'(4 * t));
      else fetch_valid = 1'b0;
      tick();
      if (t >= 1) chk("wrap_tag", {28'd0, issue_rob_tag}, 32'((t - 1) % 16));
    end

    // Illegal head is dropped; then freeze with rdy low
    do_reset();
    offer(32'h0, 32'h500); tick();
    offer(ADDI, 32'h504); tick();
    chk("illegal_noissue", {31'd0, issue_valid}, 32'd0);
    fetch_valid = 1'b0; tick();
    chk("after_illegal_valid", {31'd0, issue_valid}, 32'd1);
    chk("after_illegal_tag", {28'd0, issue_rob_tag}, 32'd0);
    rdy = 1'b0; offer(ADDI, 32'h508);
    repeat (2) tick();
    chk("frozen_valid", {31'd0, issue_valid}, 32'd1);
    chk("frozen_pc", issue_pc, 32'h504);
    rdy = 1'b1; fetch_valid = 1'b0; tick();
    chk("unfrozen_valid", {31'd0, issue_valid}, 32'd0);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 199) != 0);
      rdy         = ($urandom_range(0, 9) != 0);
      flush       = ($urandom_range(0, 29) == 0);
      rob_full    = ($urandom_range(0, 3) == 0);
      lsb_full    = ($urandom_range(0, 3) == 0);
      rs_full     = ($urandom_range(0, 3) == 0);
      fetch_valid = ($urandom_range(0, 3) != 0);
      fetch_instr = rand_instr();
      fetch_pc    = $urandom();
      fetch_isjump = $urandom_range(0, 1) != 0;
      fetch_wpc   = $urandom();
      tick();
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
